// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants for the CPU write-side steering blocks
package cpu_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int CNT_W     = 16;
   // Bit n set means NUMBER = n is a legal channel count (2, 4, 8, 16).
   localparam logic [16:0] LEGAL_NUMBERS = 17'b1_0000_0001_0001_0100;

   function automatic logic number_legal(input int n);
      return (n >= 0 && n <= 16) ? LEGAL_NUMBERS[n] : 1'b0;
   endfunction
endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register with valid flag and same-cycle load/drain
module demux_slot
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             drain,
   output logic             valid,
   output logic [WIDTH-1:0] q
);
   // A load wins over a drain so the slot refills without a bubble; q is kept after a drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/demux_reg.sv
// rtl/demux_reg.sv - registered one-to-N distributor with per-channel valid/ready
module demux_reg
   import cpu_pkg::*;
#(
   parameter int NUMBER = 4,
   parameter int SIGWID = 2,
   parameter int WIDTH  = WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SIGWID-1:0]       s,
   input  logic [WIDTH-1:0]        d,
   output logic [NUMBER-1:0]       out_valid,
   input  logic [NUMBER-1:0]       out_ready,
   output logic [NUMBER*WIDTH-1:0] y,
   output logic                    err,
   output logic [CNT_W-1:0]        count
);
   localparam int SPAN = 2 ** SIGWID;

   logic [SPAN-1:0]   in_range_pad;
   logic [SPAN-1:0]   valid_pad;
   logic [SPAN-1:0]   ready_pad;
   logic [NUMBER-1:0] load;
   logic              in_range;
   logic              accept;

   // Pad channel state out to the full select space so any s can index it safely.
   for (genvar i = 0; i < SPAN; i++) begin : g_pad
      if (i < NUMBER) begin : g_real
         assign in_range_pad[i] = 1'b1;
         assign valid_pad[i]    = out_valid[i];
         assign ready_pad[i]    = out_ready[i];
      end else begin : g_void
         assign in_range_pad[i] = 1'b0;
         assign valid_pad[i]    = 1'b0;
         assign ready_pad[i]    = 1'b0;
      end
   end

   assign in_range = in_range_pad[s];
   assign in_ready = ~in_range | ~valid_pad[s] | ready_pad[s];
   assign accept   = in_valid & in_ready;

   for (genvar i = 0; i < NUMBER; i++) begin : g_slot
      assign load[i] = accept & in_range & (s == SIGWID'(i));

      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (load[i]),
         .d     (d),
         .drain (out_ready[i]),
         .valid (out_valid[i]),
         .q     (y[i*WIDTH +: WIDTH])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err   <= 1'b0;
         count <= '0;
      end else begin
         err <= accept & ~in_range;
         if (accept & in_range) begin
            count <= count + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_demux_reg.sv
// tb/tb_demux_reg.sv - self-checking bench for demux_reg (NUMBER=4, SIGWID=3)
module tb_demux_reg;
   localparam int NUMBER = 4;
   localparam int SIGWID = 3;
   localparam int WIDTH  = 32;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [SIGWID-1:0]       s;
   logic [WIDTH-1:0]        d;
   logic [NUMBER-1:0]       out_valid;
   logic [NUMBER-1:0]       out_ready;
   logic [NUMBER*WIDTH-1:0] y;
   logic                    err;
   logic [15:0]             count;

   int checks   = 0;
   int failures = 0;

   demux_reg #(.NUMBER(NUMBER), .SIGWID(SIGWID), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s         (s),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .err       (err),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [2:0]  s;
      logic [31:0] d;
      logic [3:0]  ordy;
      logic        chk_rdy;
      logic        rdy;
      logic [3:0]  ov;
      logic        err;
      logic [15:0] cnt;
      int          slot;
      logic [31:0] slot_val;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] slot_of(input int i);
      return y[i*WIDTH +: WIDTH];
   endfunction

   logic [31:0] last_word[NUMBER];
   logic        rdy_bad;

   initial begin
      //            rst  iv  s     d              ordy     chk rdy ov       err cnt    slot val
      vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd0, 0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd0, 2, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b0, 16'd1, 2, 32'hDEADBEEF};
      vecs[3]  = '{1'b0, 1'b1, 3'd2, 32'h55,       4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0, 16'd1, 2, 32'hDEADBEEF};
      vecs[4]  = '{1'b0, 1'b1, 3'd2, 32'h11,       4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 16'd2, 2, 32'h11};
      vecs[5]  = '{1'b0, 1'b1, 3'd0, 32'hA0,       4'b0000, 1'b1, 1'b1, 4'b0101, 1'b0, 16'd3, 0, 32'hA0};
      vecs[6]  = '{1'b0, 1'b1, 3'd1, 32'h22,       4'b0000, 1'b1, 1'b1, 4'b0111, 1'b0, 16'd4, 1, 32'h22};
      vecs[7]  = '{1'b0, 1'b1, 3'd0, 32'hBB,       4'b0000, 1'b1, 1'b0, 4'b0111, 1'b0, 16'd4, 0, 32'hA0};
      vecs[8]  = '{1'b0, 1'b1, 3'd5, 32'h99,       4'b0000, 1'b1, 1'b1, 4'b0111, 1'b1, 16'd4, 0, 32'hA0};
      vecs[9]  = '{1'b0, 1'b0, 3'd5, 32'h99,       4'b0000, 1'b1, 1'b1, 4'b0111, 1'b0, 16'd4, 2, 32'h11};
      vecs[10] = '{1'b0, 1'b1, 3'd3, 32'h33,       4'b0101, 1'b1, 1'b1, 4'b1010, 1'b0, 16'd5, 3, 32'h33};
      vecs[11] = '{1'b0, 1'b0, 3'd0, 32'h0,        4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd5, 1, 32'h22};
      vecs[12] = '{1'b0, 1'b1, 3'd7, 32'h66,       4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 16'd5, 0, 32'hA0};
      vecs[13] = '{1'b1, 1'b1, 3'd1, 32'h44,       4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd0, 1, 32'h0};
      vecs[14] = '{1'b0, 1'b1, 3'd3, 32'h77,       4'b0000, 1'b1, 1'b1, 4'b1000, 1'b0, 16'd1, 3, 32'h77};
      vecs[15] = '{1'b1, 1'b0, 3'd0, 32'h0,        4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 16'd0, 3, 32'h0};

      rst = 1'b1; in_valid = 1'b0; s = '0; d = '0; out_ready = '0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         rst = vecs[i].rst; in_valid = vecs[i].iv; s = vecs[i].s;
         d = vecs[i].d; out_ready = vecs[i].ordy;
         #1;
         if (vecs[i].chk_rdy) chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
         chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_slot%0d", i, vecs[i].slot), slot_of(vecs[i].slot), vecs[i].slot_val);
      end

      // err must be a single-cycle pulse
      rst = 1'b0; in_valid = 1'b1; s = 3'd4; d = 32'h5; out_ready = '0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("err_pulse_hi", 32'(err), 32'd1);
      @(posedge clk); #1;
      chk("err_pulse_lo", 32'(err), 32'd0);
      chk("err_count_same", 32'(count), 32'd0);

      // Round-robin stream of 65537 words with every sink ready
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 4'b1111; rdy_bad = 1'b0;
      for (int k = 0; k < 65537; k++) begin
         in_valid = 1'b1;
         s = 3'(k % 4);
         d = 32'(k) ^ 32'hA5A5_0000;
         last_word[k % 4] = d;
         #1;
         if (in_ready !== 1'b1) rdy_bad = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("stream_in_ready", 32'(rdy_bad), 32'd0);
      chk("stream_count_wrap", 32'(count), 32'd1);
      chk("stream_out_valid", 32'(out_valid), 32'b0001);
      for (int i = 0; i < NUMBER; i++) begin
         chk($sformatf("stream_slot%0d", i), slot_of(i), last_word[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
